sync_tx_arbiter: RTL and testbench
==================================

// Module: sync_tx_arbiter
// PURPOSE
//  Source-side controller for the multi-bit bus synchronizer (unsync_bus + bus_enable channel).
//  Arbitrates NUM_REQ requesters round-robin onto one synchronizer channel.
//  Sequences each transfer: data setup, enable hold, idle gap, so the destination enable-sync and
//  pulse generator see one clean enable level per word with the data stable throughout.
// PARAMETERS
//  DATA_WIDTH   8  width of each requester word and of unsync_bus
//  NUM_REQ      2  number of requesters, legal range 2..4
//  HOLD_CYCLES  4  cycles bus_enable stays high per transfer, >=1; sized >= dest sync depth + 1
//  GAP_CYCLES   2  cycles bus_enable stays low after HOLD before the next grant, >=0
// PORTS
//  clk          in   1                    source-domain clock, rising edge
//  rst          in   1                    asynchronous, active-high reset
//  req          in   NUM_REQ              per-requester request level
//  req_data     in   NUM_REQ*DATA_WIDTH   requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt          out  NUM_REQ              one-cycle pulse: word of requester i captured
//  busy         out  1                    high in any state other than IDLE
//  unsync_bus   out  DATA_WIDTH           registered word to synchronizer
//  bus_enable   out  1                    registered enable level to synchronizer
//  xfer_count   out  16                   completed-transfer count (only with SYNC_TX_STATS_EN)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, gnt=0, busy=0, unsync_bus=0, bus_enable=0,
//    rr pointer=NUM_REQ-1 (req[0] wins first), hold/gap counter=0, xfer_count=0.
//  - All outputs registered; no combinational path from req to any output.
//  - FSM: IDLE -> SETUP -> HOLD -> GAP -> IDLE.
//    IDLE : req sampled at each edge; if any bit set, winner w chosen, next cycle = SETUP.
//    SETUP: 1 cycle; unsync_bus=req_data[w] (captured on entry edge), gnt[w]=1, bus_enable=0.
//    HOLD : exactly HOLD_CYCLES cycles, bus_enable=1, unsync_bus unchanged.
//    GAP  : exactly GAP_CYCLES cycles, bus_enable=0, unsync_bus unchanged;
//           GAP_CYCLES=0 -> HOLD goes directly to IDLE.
//  - Latency: req high at edge k -> gnt and new unsync_bus visible after edge k, bus_enable rises
//    after edge k+1. Minimum gnt-to-gnt spacing = HOLD_CYCLES+GAP_CYCLES+2 (8 at defaults).
//  - Round-robin: search starts at pointer+1 mod NUM_REQ; pointer := w on grant.
//    Idle requesters do not move the pointer.
//  - Requester holds req and req_data until it sees gnt; must drop req the cycle after gnt or it
//    requests again. req is ignored outside IDLE; pulses shorter than the next IDLE sample are lost.
//  - unsync_bus holds last word after return to IDLE (never glitches while bus_enable=1).
//  - busy=1 from SETUP entry through last GAP cycle; 0 in IDLE.
//  - Counter width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); counter reloads on state entry.
// CONFIGURATION
//  - SYNC_TX_STATS_EN defined: xfer_count port present, increments by 1 on the last HOLD cycle,
//    wraps 16'hFFFF -> 16'h0000, cleared only by rst.
//  - SYNC_TX_STATS_EN undefined: xfer_count port and counter absent; all other behaviour identical.
// TESTING (defaults: DATA_WIDTH=8, NUM_REQ=2, HOLD_CYCLES=4, GAP_CYCLES=2)
//  1 Assert rst for 3 cycles with req=2'b11 -> gnt=0, busy=0, unsync_bus=8'h00, bus_enable=0.
//  2 req=2'b01, data0=8'hA5 -> gnt=2'b01 for 1 cycle; unsync_bus=8'hA5; bus_enable high exactly
//    4 cycles starting 1 cycle after gnt; busy low 7 cycles after gnt.
//  3 req=2'b11 held, data0=8'h11, data1=8'h22 -> gnt order 0,1,0,1, gnt spacing 8 cycles,
//    unsync_bus alternates 8'h11/8'h22.
//  4 rst pulsed during 2nd HOLD cycle of req1 transfer -> bus_enable/busy drop immediately
//    (async); after release with req=2'b11, req[0] is granted first.
//  5 req[1] single-cycle pulse during HOLD -> no gnt[1], no extra transfer.
//  6 SYNC_TX_STATS_EN: 3 transfers -> xfer_count=3; preload 16'hFFFF + 1 transfer -> 16'h0000.

Source files
------------

// File: rtl/sync_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sync_tx_arbiter
//   Source-side controller for a multi-bit bus synchronizer (unsync_bus plus a
//   bus_enable qualifier). NUM_REQ requesters are arbitrated round-robin onto
//   the single channel. Each transfer is sequenced in four phases:
//     SETUP : 1 cycle, word captured and gnt pulsed, enable still low
//     HOLD  : HOLD_CYCLES cycles with bus_enable high and the word stable
//     GAP   : GAP_CYCLES cycles with bus_enable low (skipped when 0)
//     IDLE  : waiting for requests
//   The destination therefore sees one clean enable level per word, with the
//   data already stable for a cycle before the enable rises.
//
// Optional feature macro: SYNC_TX_STATS_EN
//   When defined, adds xfer_count_o, a 16-bit wrapping count of completed
//   transfers, bumped on the last HOLD cycle and cleared only by reset.
//
// Ports
//   clk_i         source-domain clock, rising edge
//   rst_i         asynchronous active-high reset
//   req_i         per-requester request level
//   req_data_i    requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o         one-cycle pulse: word of requester i captured
//   busy_o        high in every state except IDLE
//   unsync_bus_o  registered word to the synchronizer
//   bus_enable_o  registered enable level to the synchronizer
//   xfer_count_o  completed-transfer count (SYNC_TX_STATS_EN only)
// -----------------------------------------------------------------------------
module sync_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          busy_o,
  output logic [DATA_WIDTH-1:0]         unsync_bus_o,
  output logic                          bus_enable_o
`ifdef SYNC_TX_STATS_EN
  ,
  output logic [15:0]                   xfer_count_o
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  // Counters load N-1 on phase entry and the phase ends when they reach zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HOLD,
    S_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   bus_q, bus_d;
  logic                    en_q, en_d;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [DATA_WIDTH-1:0]   win_word;

  // Round-robin pick: scan starts one past the last winner so the most
  // recently served requester has the lowest priority.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign win_word = req_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    bus_d   = bus_q;
    en_d    = en_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_SETUP;
          ptr_d          = win_idx;
          bus_d          = win_word;
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          en_d           = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_HOLD;
        en_d    = 1'b1;
        cnt_d   = HOLD_LOAD;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          en_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      bus_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = busy_q;
  assign unsync_bus_o = bus_q;
  assign bus_enable_o = en_q;

`ifdef SYNC_TX_STATS_EN
  logic [15:0] xfer_cnt_q;

  // A transfer counts as complete on its last HOLD cycle; wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xfer_cnt_q <= '0;
    end else if (state_q == S_HOLD && cnt_q == '0) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_count_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_sync_tx_arbiter.sv
module tb_sync_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  bus;
  logic        en;
`ifdef SYNC_TX_STATS_EN
  logic [15:0] xfer_count;
`endif

  int checks = 0;
  int errors = 0;

  sync_tx_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (2),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_data_i  (req_data),
    .gnt_o       (gnt),
    .busy_o      (busy),
    .unsync_bus_o(bus),
    .bus_enable_o(en)
`ifdef SYNC_TX_STATS_EN
    ,
    .xfer_count_o(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

`ifdef SYNC_TX_STATS_EN
  task automatic one_xfer();
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (8) tick();
  endtask
`endif

  initial begin
    int cyc;
    int last;
    int n;
    logic seen;

    rst      = 1'b1;
    req      = 2'b11;
    req_data = 16'h0000;

    // 1: reset held 3 cycles with requests pending
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bus", 32'(bus), 32'h00);
    check("rst_en", 32'(en), 32'h0);
`ifdef SYNC_TX_STATS_EN
    check("rst_cnt", 32'(xfer_count), 32'h0);
`endif

    // 2: single transfer from requester 0
    rst      = 1'b0;
    req      = 2'b01;
    req_data = 16'h00A5;
    tick();
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_bus", 32'(bus), 32'hA5);
    check("t2_en_setup", 32'(en), 32'h0);
    check("t2_busy_setup", 32'(busy), 32'h1);
    req = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("t2_en_%0d", i), 32'(en), (i <= 4) ? 32'h1 : 32'h0);
      check($sformatf("t2_busy_%0d", i), 32'(busy), (i <= 6) ? 32'h1 : 32'h0);
      check($sformatf("t2_gnt_%0d", i), 32'(gnt), 32'h0);
    end
    check("t2_bus_hold", 32'(bus), 32'hA5);

    // 3: both requesting continuously, fresh pointer -> 0,1,0,1 every 8 cycles
    reset_pulse();
    req      = 2'b11;
    req_data = 16'h2211;
    cyc  = 0;
    last = -1;
    n    = 0;
    while (n < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (gnt != 2'b00) begin
        check($sformatf("t3_gnt_%0d", n), 32'(gnt), (n % 2 == 1) ? 32'h2 : 32'h1);
        check($sformatf("t3_bus_%0d", n), 32'(bus), (n % 2 == 1) ? 32'h22 : 32'h11);
        if (last >= 0) check($sformatf("t3_gap_%0d", n), 32'(cyc - last), 32'd8);
        last = cyc;
        n++;
      end
    end
    check("t3_grants", 32'(n), 32'd4);

    // 4: async reset in 2nd HOLD cycle of the requester-1 transfer
    tick();
    tick();
    check("t4_en_hold", 32'(en), 32'h1);
    rst = 1'b1;
    #1;
    check("t4_en_async", 32'(en), 32'h0);
    check("t4_busy_async", 32'(busy), 32'h0);
    check("t4_bus_async", 32'(bus), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    check("t4_gnt_first", 32'(gnt), 32'h1);
    check("t4_bus_first", 32'(bus), 32'h11);
    req = 2'b00;
    repeat (8) tick();
    check("t4_idle", 32'(busy), 32'h0);

    // 5: short req[1] pulse during HOLD is lost
    req      = 2'b01;
    req_data = 16'h335A;
    tick();
    check("t5_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    req = 2'b10;
    tick();
    req  = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 2'b00) seen = 1'b1;
    end
    check("t5_no_gnt", 32'(seen), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_bus_kept", 32'(bus), 32'h5A);

`ifdef SYNC_TX_STATS_EN
    // 6: transfer counter and wrap
    reset_pulse();
    req_data = 16'h0077;
    repeat (3) one_xfer();
    check("t6_cnt3", 32'(xfer_count), 32'd3);
    dut.xfer_cnt_q = 16'hFFFF;
    one_xfer();
    check("t6_wrap", 32'(xfer_count), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
